// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
//  Module   : alu_sequencer_pkg
//  Purpose  : Opcodes, flag width and state encoding shared by the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam logic [1:0] OP_NOR  = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_SUM  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

    localparam int FLAG_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_A  = 3'd1,
        ST_LD_B  = 3'd2,
        ST_LD_OP = 3'd3,
        ST_UPD   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_RESP  = 3'd6
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Loads one command into the alu (A, B, opcode, update), captures
//             result/flags and returns them on a valid/ready response port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int N        = 16,
    parameter int RES_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N-1:0]      cmd_a,
    input  logic [N-1:0]      cmd_b,
    input  logic [1:0]        cmd_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [N-1:0]      alu_data_in,
    output logic              alu_load_A,
    output logic              alu_load_B,
    output logic              alu_load_Op,
    output logic              alu_updateRes,
    input  logic [N-1:0]      alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              busy,
    output logic [15:0]       ops_done
);

    localparam int C_WAIT_W = (RES_WAIT > 1) ? $clog2(RES_WAIT) : 1;

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic                w_accept;
    logic                w_last_wait;
    logic                w_rsp_fire;
    logic [N-1:0]        w_data_next;

    logic [N-1:0]        r_op_b;
    logic [1:0]          r_op_code;
    logic [C_WAIT_W-1:0] r_wait_cnt;
    logic [N-1:0]        r_data_in;
    logic                r_load_a;
    logic                r_load_b;
    logic                r_load_op;
    logic                r_update;
    logic                r_rsp_valid;
    logic [N-1:0]        r_rsp_result;
    logic [FLAG_W-1:0]   r_rsp_flags;
    logic [15:0]         r_ops_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last_wait  = 1'b0;
        w_rsp_fire   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_LD_A;
                end
            end
            ST_LD_A:  w_state_next = ST_LD_B;
            ST_LD_B:  w_state_next = ST_LD_OP;
            ST_LD_OP: w_state_next = ST_UPD;
            ST_UPD:   w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_last_wait  = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // LD_A is only entered on the accept edge, so A goes straight from the
        // command port into the data register; B and opcode come from the latch.
        unique case (w_state_next)
            ST_LD_A:  w_data_next = cmd_a;
            ST_LD_B:  w_data_next = r_op_b;
            ST_LD_OP: w_data_next = {{(N-2){1'b0}}, r_op_code};
            default:  w_data_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op_b       <= '0;
            r_op_code    <= '0;
            r_wait_cnt   <= '0;
            r_data_in    <= '0;
            r_load_a     <= 1'b0;
            r_load_b     <= 1'b0;
            r_load_op    <= 1'b0;
            r_update     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_ops_done   <= '0;
        end else begin
            r_data_in <= w_data_next;
            r_load_a  <= (w_state_next == ST_LD_A);
            r_load_b  <= (w_state_next == ST_LD_B);
            r_load_op <= (w_state_next == ST_LD_OP);
            r_update  <= (w_state_next == ST_UPD);

            if (w_accept) begin
                r_op_b    <= cmd_b;
                r_op_code <= cmd_op;
            end

            if (r_state == ST_UPD) begin
                r_wait_cnt <= C_WAIT_W'(RES_WAIT - 1);
            end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (w_last_wait) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_flags  <= alu_flags;
            end else if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + 16'd1;
            end
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign alu_data_in   = r_data_in;
    assign alu_load_A    = r_load_a;
    assign alu_load_B    = r_load_b;
    assign alu_load_Op   = r_load_op;
    assign alu_updateRes = r_update;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;
    assign ops_done      = r_ops_done;

endmodule

`default_nettype wire
